// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle for the bit-serial adder
//
// Purpose: groups the request (start, a, b, cin) and result (busy, done,
// sum, cout, ovf) signals of serial_adder into one port.
// Ports (modport master = requester, modport slave = adder):
//   start  request an addition (sampled only while the adder is idle)
//   a, b   WIDTH-bit operands, cin carry-in
//   busy   addition in progress
//   done   one-cycle pulse, sum/cout/ovf valid
//   sum    WIDTH-bit result, cout carry out, ovf signed overflow
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial two-operand adder with one full-adder cell
//
// Purpose: adds two WIDTH-bit operands plus carry-in one bit pair per clock,
// LSB first, shifting each sum bit into the result register from the MSB side.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout/ovf out
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_a_q, shift_a_d;
  logic [WIDTH-1:0]   shift_b_q, shift_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // The single full-adder slice.
  logic fa_s;
  logic fa_c;

  assign fa_s = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
  assign fa_c = (shift_a_q[0] & shift_b_q[0]) |
                (shift_a_q[0] & carry_q)      |
                (shift_b_q[0] & carry_q);

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_a_d = bus.a;
          shift_b_d = bus.b;
          carry_d   = bus.cin;
          cnt_d     = '0;
          state_d   = RUN;
          busy_d    = 1'b1;
        end
      end

      RUN: begin
        sum_d     = {fa_s, sum_q[WIDTH-1:1]};
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        carry_d   = fa_c;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB on this last step.
          ovf_d   = carry_q ^ fa_c;
          cout_d  = fa_c;
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8, 2 and 16
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint sum;
    bit     cout;
    bit     ovf;
  } exp_t;

  exp_t q8[$];
  bit   sweep_go = 1'b0;
  bit   sweep_fin[2];

  serial_adder_if #(.WIDTH(W)) bus8 ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t ref_add(int w, longint a, longint b, bit c);
    exp_t   r;
    longint m, tot, sa, sb, st;
    m      = longint'(1) << w;
    tot    = a + b + longint'(c);
    r.sum  = tot % m;
    r.cout = (tot >= m);
    sa     = (a >= m / 2) ? a - m : a;
    sb     = (b >= m / 2) ? b - m : b;
    st     = sa + sb + longint'(c);
    r.ovf  = (st < -(m / 2)) || (st >= m / 2);
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8_done_without_pending", q8.size(), 1);
      end else begin
        e = q8.pop_front();
        check("w8_sum", bus8.sum, e.sum);
        check("w8_cout", bus8.cout, e.cout);
        check("w8_ovf", bus8.ovf, e.ovf);
      end
    end
  end

  // Call at a negedge; returns one negedge after the accepting edge.
  task automatic op_start8(logic [W-1:0] a, logic [W-1:0] b, bit c, bit push);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = c;
    if (push) q8.push_back(ref_add(W, a, b, c));
    @(negedge clk);
    bus8.start = 1'b0;
    check("w8_busy_after_accept", bus8.busy, 1);
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (bus8.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.cout, 0);
    check("rst_ovf", bus8.ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operand sets.
    begin
      logic [W-1:0] ta[3];
      logic [W-1:0] tb[3];
      bit           tc[3];
      ta = '{8'h5A, 8'hFF, 8'h7F};
      tb = '{8'h3C, 8'h01, 8'h00};
      tc = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
        op_start8(ta[i], tb[i], tc[i], 1'b1);
        wait_done8(n);
        check("directed_latency", n, W);
        check("directed_busy_at_done", bus8.busy, 0);
        @(negedge clk);
        check("directed_done_one_cycle", bus8.done, 0);
      end
    end

    // start held high: operand change during RUN ignored, re-accept in done cycle.
    bus8.start = 1'b1;
    bus8.a     = 8'h01;
    bus8.b     = 8'h02;
    bus8.cin   = 1'b0;
    q8.push_back(ref_add(W, 8'h01, 8'h02, 1'b0));
    @(negedge clk);
    check("b2b_busy_first", bus8.busy, 1);
    repeat (2) @(negedge clk);
    bus8.a = 8'h10;
    wait_done8(n);
    check("b2b_first_latency", n, W - 2);
    q8.push_back(ref_add(W, 8'h10, 8'h02, 1'b0));
    @(negedge clk);
    check("b2b_busy_rises", bus8.busy, 1);
    check("b2b_done_falls", bus8.done, 0);
    bus8.start = 1'b0;
    wait_done8(n);
    check("b2b_second_latency", n, W);
    @(negedge clk);

    // start pulsed in the 3rd RUN cycle must be ignored.
    op_start8(8'h11, 8'h22, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'h77;
    bus8.b     = 8'h66;
    bus8.cin   = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(n);
    check("busy_start_latency", n, W - 3);
    repeat (W + 3) @(negedge clk);
    check("busy_start_no_extra", q8.size(), 0);

    // Asynchronous reset in the 4th RUN cycle.
    op_start8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_sum", bus8.sum, 0);
    check("abort_cout", bus8.cout, 0);
    check("abort_ovf", bus8.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_no_done", bus8.done, 0);
    op_start8(8'h80, 8'h80, 1'b0, 1'b1);
    wait_done8(n);
    check("after_abort_latency", n, W);
    @(negedge clk);

    // Randomised sweep, run alongside the WIDTH=2/16 sweeps.
    sweep_go = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      bit           rc;
      ra = (i < 4) ? ((i & 1) != 0 ? '1 : '0) : W'($urandom());
      rb = (i < 4) ? ((i & 2) != 0 ? '1 : '0) : W'($urandom());
      rc = 1'($urandom());
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op_start8(ra, rb, rc, 1'b1);
      wait_done8(n);
      check("rand_latency", n, W);
    end
    @(negedge clk);
    check("w8_queue_drained", q8.size(), 0);

    for (int k = 0; k < 20000 && !(sweep_fin[0] && sweep_fin[1]); k++) @(negedge clk);
    check("sweeps_finished", {sweep_fin[0], sweep_fin[1]}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Extra builds at the width extremes, each with its own scoreboard.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 2 : 16;

    exp_t q[$];
    serial_adder_if #(.WIDTH(SW)) sif ();
    serial_adder #(.WIDTH(SW)) sdut (.clk(clk), .rst_n(rst_n), .bus(sif));

    always @(negedge clk) begin
      exp_t e;
      if (sif.done === 1'b1) begin
        if (q.size() == 0) begin
          check("sw_done_without_pending", q.size(), 1);
        end else begin
          e = q.pop_front();
          check("sw_sum", sif.sum, e.sum);
          check("sw_cout", sif.cout, e.cout);
          check("sw_ovf", sif.ovf, e.ovf);
        end
      end
    end

    initial begin
      sif.start = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      sif.cin   = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 300; i++) begin
        logic [SW-1:0] av, bv;
        bit            cv;
        int            n;
        av = (i < 4) ? ((i & 1) != 0 ? '1 : '0) : SW'($urandom());
        bv = (i < 4) ? ((i & 2) != 0 ? '1 : '0) : SW'($urandom());
        cv = 1'($urandom());
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = av;
        sif.b     = bv;
        sif.cin   = cv;
        q.push_back(ref_add(SW, av, bv, cv));
        @(negedge clk);
        sif.start = 1'b0;
        n = 0;
        while (sif.done !== 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("sw_latency", n, SW);
      end
      @(negedge clk);
      check("sw_queue_drained", q.size(), 0);
      sweep_fin[g] = 1'b1;
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial two-operand adder built around one full-adder cell and a registered carry.
- Loads WIDTH-bit operands, feeds one bit pair per clock (LSB first) into the cell, and shifts the result into a sum register.
- Sits upstream of the register file/ALU result path. Trades WIDTH cycles of latency for a single full-adder slice.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; marks sum/cout/ovf as valid.
- sum  output  WIDTH  result; held stable until the next accepted start.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state (rst_n low, immediate, no clock needed):
  - state = IDLE; busy = 0; done = 0.
  - sum = 0; cout = 0; ovf = 0.
  - carry register = 0; bit counter = 0.
  - Operand shift registers = 0.
- States: IDLE and RUN.
- IDLE:
  - start = 1 at a rising edge: load a, b into the shift registers and cin into the carry register; clear the counter.
  - On that edge: go to RUN, busy <= 1, done <= 0.
  - start = 0: remain in IDLE; sum/cout/ovf hold their values.
- RUN, each edge:
  - Full-adder inputs: A = shiftA[0], B = shiftB[0], Cin = carry.
  - The cell's S shifts into sum from the MSB side, so after WIDTH shifts bit 0 is the LSB.
  - shiftA and shiftB shift right by one; carry <= the cell's Cout; counter increments.
  - On the edge where the counter == WIDTH-1 (the WIDTH-th RUN edge):
    - ovf <= carry XOR the cell's Cout (carry is the carry into the MSB at that point).
    - cout <= the cell's Cout.
    - Go to IDLE; busy <= 0; done <= 1.
- Latency: start is accepted at edge E0. busy is high from E0 to E_WIDTH. done is high for exactly the one cycle between E_WIDTH and E_WIDTH+1.
- done is cleared on every edge that does not set it.
- start while busy: ignored. No queuing, and operands are not re-sampled.
- start during the done cycle: state is IDLE, so it is accepted. This gives back-to-back operation with no bubble: done falls and busy rises on the same edge.
- sum bits are intermediate (partially shifted) while busy = 1. They are valid only from the done cycle onward.
- Changes on a/b/cin after the accepting edge have no effect on the current operation.
- rst_n asserted mid-operation: abort immediately to the reset state. No done pulse is produced.
- Deasserting rst_n is synchronised externally. The block needs no special recovery logic.
- Arithmetic is modulo 2^WIDTH. The carry register is 1 bit. The counter is ceil(log2(WIDTH)) bits wide and never wraps past WIDTH-1.

Test Plan:
- WIDTH=8; reset, then start with a=0x5A, b=0x3C, cin=0 -> busy high for 8 cycles; then done=1 for 1 cycle with sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- start=1 held continuously with a=0x01, b=0x02, cin=0, changing a to 0x10 during RUN -> first result sum=0x03. Then re-accepted in the done cycle: busy high again on the following edge, next result sum=0x12.
- Pulse start while busy (3rd RUN cycle) with different operands -> ignored. Result is from the original operands, done occurs exactly 8 cycles after the original accept, and there is no extra done.
- Pull rst_n low at the 4th RUN cycle, asynchronously between edges -> busy, done, sum, cout and ovf go to 0 immediately. After release, state is IDLE; a new start of 0x80+0x80 gives sum=0x00, cout=1, ovf=1.
- Randomised sweep, 1000 operand pairs plus cin, including WIDTH=2 and WIDTH=16 builds -> {cout,sum} == a+b+cin and ovf matches the signed-overflow reference every time.
